// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the one-hot ring counter.
package ring_counter_pkg;

  localparam int RING_WIDTH_DEF = 4;

  // Single-hot reset pattern: only the most significant stage set.
  function automatic logic [31:0] init_onehot(input int width);
    return 32'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/ring_counter_design_onehot_check.sv
// Combinational one-hot detector: true when exactly one bit of vec is set.
module onehot_check #(
  parameter int WIDTH = ring_counter_pkg::RING_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] vec,
  output logic             is_onehot
);

  logic seen;
  logic multi;

  // Sweep the bits once: multi latches when a set bit follows an earlier one.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      multi = multi | (seen & vec[i]);
      seen  = seen | vec[i];
    end
    is_onehot = seen & ~multi;
  end

endmodule

// File: rtl/ring_counter_design.sv
// One-hot ring counter rotating right each clock, with self-correction
// back to the reset pattern whenever the ring is not exactly one-hot.
module ring_counter_design
  import ring_counter_pkg::*;
#(
  parameter int               WIDTH       = RING_WIDTH_DEF,
  parameter logic [WIDTH-1:0] INIT_ONEHOT = WIDTH'(init_onehot(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  logic is_onehot;

  onehot_check #(.WIDTH(WIDTH)) u_onehot (
    .vec       (q),
    .is_onehot (is_onehot)
  );

  // Reset wins over correction; correction wins over rotation.
  always_ff @(posedge clk) begin
    if (rst)
      q <= INIT_ONEHOT;
    else if (!is_onehot)
      q <= INIT_ONEHOT;
    else
      q <= {q[0], q[WIDTH-1:1]};
  end

endmodule

// File: tb/tb_ring_counter_design.sv
// Randomized self-checking bench for ring_counter_design (WIDTH=4 and WIDTH=8).
module tb_ring_counter_design;

  logic       clk;
  logic       rst;
  logic       rst8;
  logic [3:0] q;
  logic [7:0] q8;

  int passed = 0;
  int total  = 0;
  int hot4;
  int hot8;

  ring_counter_design dut (
    .clk (clk),
    .rst (rst),
    .q   (q)
  );

  ring_counter_design #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .q   (q8)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference model: track the index of the hot bit; rotating right lowers it.
  function automatic int rot(input int h, input int w);
    return (h == 0) ? w - 1 : h - 1;
  endfunction

  function automatic int after_value(input logic [31:0] v, input int w);
    int idx;
    idx = 0;
    if ($countones(v) != 1) return w - 1;
    for (int i = 0; i < w; i++) if (v[i]) idx = i;
    return rot(idx, w);
  endfunction

  function automatic logic [31:0] hot_vec(input int h);
    return 32'(1) << h;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    hot4 = 3;
    total++;
    if (q !== 4'b1000) $display("FAIL reset q=%b expected=1000", q);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    logic [3:0] seq [4];
    seq[0] = 4'b0100; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step();
      hot4 = rot(hot4, 4);
      total++;
      if (q !== seq[i]) $display("FAIL sequence[%0d] q=%b expected=%b", i, q, seq[i]);
      else passed++;
    end
  endtask

  task automatic test_free_run();
    logic [3:0] hist [$];
    for (int i = 0; i < 10; i++) begin
      step();
      hot4 = rot(hot4, 4);
      hist.push_back(q);
      total++;
      if ($countones(q) != 1 || q !== 4'(hot_vec(hot4)) ||
          (hist.size() > 4 && q !== hist[hist.size() - 5]))
        $display("FAIL free_run[%0d] q=%b expected=%b", i, q, 4'(hot_vec(hot4)));
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (q !== 4'b0010 && n < 8) begin
      step();
      hot4 = rot(hot4, 4);
      n++;
    end
    total++;
    if (q !== 4'b0010) $display("FAIL mid_reset_reach q=%b expected=0010", q);
    else passed++;
    rst = 1'b1;
    step();
    hot4 = 3;
    total++;
    if (q !== 4'b1000) $display("FAIL mid_reset_apply q=%b expected=1000", q);
    else passed++;
    rst = 1'b0;
    step();
    hot4 = rot(hot4, 4);
    total++;
    if (q !== 4'b0100) $display("FAIL mid_reset_resume q=%b expected=0100", q);
    else passed++;
  endtask

  task automatic test_self_correct();
    logic [3:0] bad [2];
    bad[0] = 4'b0000; bad[1] = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      force dut.q = bad[i];
      #1 release dut.q;
      step();
      hot4 = after_value(32'(bad[i]), 4);
      total++;
      if (q !== 4'b1000) $display("FAIL self_correct[%b] q=%b expected=1000", bad[i], q);
      else passed++;
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] v;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rst = 1'b1;
        step();
        hot4 = 3;
        rst = 1'b0;
      end else if (r == 1) begin
        v = 4'($urandom);
        force dut.q = v;
        #1 release dut.q;
        step();
        hot4 = after_value(32'(v), 4);
      end else begin
        step();
        hot4 = rot(hot4, 4);
      end
      total++;
      if (q !== 4'(hot_vec(hot4))) $display("FAIL random[%0d] r=%0d q=%b expected=%b", i, r, q, 4'(hot_vec(hot4)));
      else passed++;
    end
  endtask

  task automatic test_width8();
    logic [7:0] v;
    total++;
    if (q8 !== 8'h80) $display("FAIL w8_reset q=%b expected=10000000", q8);
    else passed++;
    hot8 = 7;
    rst8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      hot8 = rot(hot8, 8);
      total++;
      if (q8 !== 8'(hot_vec(hot8))) $display("FAIL w8_step[%0d] q=%b expected=%b", i, q8, 8'(hot_vec(hot8)));
      else passed++;
      if (i == 6) begin
        total++;
        if (q8 !== 8'h01) $display("FAIL w8_prewrap q=%b expected=00000001", q8);
        else passed++;
      end
    end
    total++;
    if (q8 !== 8'h80) $display("FAIL w8_wrap q=%b expected=10000000", q8);
    else passed++;
    v = 8'b0010_0100;
    force dut8.q = v;
    #1 release dut8.q;
    step();
    total++;
    if (q8 !== 8'h80) $display("FAIL w8_self_correct q=%b expected=10000000", q8);
    else passed++;
  endtask

  initial begin
    rst  = 1'b1;
    rst8 = 1'b1;
    test_reset();
    test_sequence();
    test_free_run();
    test_mid_reset();
    test_self_correct();
    test_random();
    test_width8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ring_counter_design.md
RING_COUNTER_DESIGN -- requirements
Module: ring_counter_design

Interface
REQ-001 Parameter: WIDTH, 4, number of ring stages (legal range 2..32).
REQ-002 Parameter: INIT_ONEHOT, WIDTH'(1) << (WIDTH-1) (4'b1000 for WIDTH=4), the single-hot value loaded on reset.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: q  output  WIDTH  ring state, driven directly from flops (no combinational path from inputs).
REQ-006 Port order SHALL be clk, rst, q so positional instantiation works.

Function
REQ-007 The block SHALL be a one-hot ring counter rotating right by one position per clock: next q = {q[0], q[WIDTH-1:1]}.
REQ-008 For WIDTH=4 the sequence after reset SHALL be 1000 -> 0100 -> 0010 -> 0001 -> 1000, period WIDTH cycles.
REQ-009 Wrap-around: when q[0]=1, the next edge SHALL set q[WIDTH-1]=1 and clear all other bits.
REQ-010 Latency: the first rotation SHALL occur on the first rising edge at which rst is sampled low.
REQ-011 Self-correction: if q is not exactly one-hot (all-zero or more than one bit set), the next edge SHALL load INIT_ONEHOT instead of rotating.
REQ-012 A one-hot detector SHALL evaluate the current q combinationally; its result SHALL only affect the next-state mux, never q directly.
REQ-013 No enable input exists; the counter SHALL advance on every non-reset edge.
REQ-014 Outputs SHALL be X-free from the first reset edge onward.

Reset
REQ-015 On a rising edge with rst=1, q SHALL become INIT_ONEHOT (4'b1000), irrespective of its current value.
REQ-016 rst SHALL have priority over rotation and over self-correction.
REQ-017 Reset asserted mid-sequence SHALL return q to INIT_ONEHOT on the next edge; rotation restarts from there after release.
REQ-018 Before the first reset edge, q SHALL be considered undefined; no power-on initialiser is required.

Structure
REQ-019 A shared package ring_counter_pkg SHALL hold the default WIDTH constant and a function computing INIT_ONEHOT from WIDTH.
REQ-020 The one-hot check SHALL be a sub-module onehot_check (input vec[WIDTH], output is_onehot), instantiated once.
REQ-021 The state register and next-state logic SHALL live in a single clocked process in ring_counter_design.

Verification
REQ-022 clk period 20 ns; rst=1 from t=0 to t=20 ns -> q=1000 after the 10 ns edge.
REQ-023 Release rst at 20 ns -> q=0100 at 30 ns, 0010 at 50 ns, 0001 at 70 ns, 1000 at 90 ns (wrap).
REQ-024 Run 200 ns free -> q repeats with period 4 cycles, exactly one bit set at every edge.
REQ-025 Assert rst for one cycle while q=0010 -> q=1000 on that edge, 0100 on the following edge.
REQ-026 Force q to 0000, release -> next edge q=1000; force q to 0110, release -> next edge q=1000.
REQ-027 Instantiate with WIDTH=8 -> reset value 10000000, wraps from 00000001 back to 10000000 after 8 cycles.
